// File: rtl/simon_pkg.sv
// Shared types for the sequence playback block: FSM states, color index, tone table.
package simon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_TONE  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   typedef logic [1:0] color_t;

   localparam logic [9:0] GAME_TONES [4] = '{10'd415, 10'd310, 10'd252, 10'd209};

   // Tone frequency for a color index.
   function automatic logic [9:0] tone_of(input color_t c);
      return GAME_TONES[c];
   endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter with zero flag; holds at zero, load wins over decrement.
module step_timer #(
   parameter int TIMER_W = 26
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] cnt_q;

   // Counter register: load, else count down toward zero.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (load_i)
         cnt_q <= load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_q <= cnt_q - 1'b1;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_playback_ctrl.sv
// Plays sequence memory entries 0..len-1 as timed LED/tone steps separated by silent gaps.
module seq_playback_ctrl
   import simon_pkg::*;
#(
   parameter int ON_CYCLES  = 25_000_000,
   parameter int GAP_CYCLES = 12_500_000,
   parameter int TIMER_W    = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [4:0] seq_length,
   output logic       mem_rd_en,
   output logic [4:0] mem_addr,
   input  logic [1:0] mem_data,
   output logic [3:0] led,
   output logic [9:0] frequency,
   output logic       busy,
   output logic       done
);

   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [4:0] len_q, len_d;
   color_t     color_q, color_d;

   logic               tmr_load, tmr_dec, tmr_zero;
   logic [TIMER_W-1:0] tmr_val;

   step_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         color_q <= color_d;
      end
   end

   // Next-state, timer control and outputs; outputs depend only on registered state.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      color_d   = color_q;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      tmr_val   = ON_LOAD;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      led       = '0;
      frequency = '0;
      busy      = (state_q != ST_IDLE);
      done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               len_d   = seq_length;
               idx_d   = '0;
               state_d = (seq_length != '0) ? ST_FETCH : ST_DONE;
            end
         end
         ST_FETCH: begin
            mem_rd_en = 1'b1;
            mem_addr  = idx_q;
            state_d   = ST_LOAD;
         end
         ST_LOAD: begin
            color_d  = mem_data;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
            state_d  = ST_TONE;
         end
         ST_TONE: begin
            led       = 4'b0001 << color_q;
            frequency = tone_of(color_q);
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
               state_d  = ST_GAP;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               if (idx_q == len_q - 5'd1) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = ST_FETCH;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort beats start and timer expiry; abandon the step without side effects.
      if (abort && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         idx_d    = idx_q;
         color_d  = color_q;
         tmr_load = 1'b0;
         tmr_dec  = 1'b0;
      end
   end

endmodule

// File: doc/seq_playback_ctrl.md
SEQ_PLAYBACK_CTRL -- requirements
Module: seq_playback_ctrl

Interface
REQ-001 Parameter ON_CYCLES, default 25_000_000, tone/LED on-time per step in clk cycles; legal range >=1.
REQ-002 Parameter GAP_CYCLES, default 12_500_000, silent gap after each step in clk cycles; legal range >=1.
REQ-003 Parameter TIMER_W, default 26, width of the step timer; must satisfy 2^TIMER_W > max(ON_CYCLES, GAP_CYCLES).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  single-cycle request to play sequence entries 0..seq_length-1.
REQ-007 abort  input  1  terminate playback immediately.
REQ-008 seq_length  input  5  number of entries to play; sampled only when start is accepted.
REQ-009 mem_rd_en  output  1  sequence-memory read strobe.
REQ-010 mem_addr  output  5  sequence-memory address.
REQ-011 mem_data  input  2  color index from sequence memory; valid the cycle after mem_rd_en.
REQ-012 led  output  4  one-hot color LED drive.
REQ-013 frequency  output  10  tone frequency to tone generator; 0 = silent.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at end of a completed, non-aborted playback.

Function
REQ-016 States: IDLE, FETCH, LOAD, TONE_ON, GAP, DONE; encoding in the shared package.
REQ-017 IDLE: start=1 and abort=0 -> latch seq_length into len_q, clear idx; next FETCH if seq_length>0, else DONE.
REQ-018 FETCH: one cycle; mem_rd_en=1, mem_addr=idx; next LOAD.
REQ-019 LOAD: one cycle; capture mem_data into cur_color; load timer with ON_CYCLES-1; next TONE_ON.
REQ-020 TONE_ON: exactly ON_CYCLES cycles; led=1<<cur_color, frequency=GAME_TONES[cur_color]; at timer==0 load GAP_CYCLES-1 and go to GAP.
REQ-021 GAP: exactly GAP_CYCLES cycles; led=0, frequency=0; at timer==0 go to DONE if idx==len_q-1, else idx+1 and FETCH.
REQ-022 DONE: one cycle; done=1; next IDLE.
REQ-023 Per-step period is 2+ON_CYCLES+GAP_CYCLES cycles; done asserts 1+len_q*(2+ON_CYCLES+GAP_CYCLES) cycles after the start cycle (1 cycle for len_q=0).
REQ-024 start while busy is ignored; seq_length changes while busy have no effect.
REQ-025 abort in any non-IDLE state -> IDLE next cycle; no done pulse; led and frequency 0 from that cycle on; abort has priority over start and timer expiry.
REQ-026 Outside FETCH: mem_rd_en=0, mem_addr=0. Outside TONE_ON: led=0, frequency=0.
REQ-027 idx and len_q are 5 bits; len_q=31 plays addresses 0..30 with no wrap; idx never exceeds len_q-1.
REQ-028 Timer is a TIMER_W-bit down-counter; no combinational path from mem_data to led/frequency.

Reset
REQ-029 rst_n=0 at a clk edge -> state IDLE, idx=0, len_q=0, cur_color=0, timer=0; takes priority over start and abort.
REQ-030 During and after reset until a start: mem_rd_en=0, mem_addr=0, led=0, frequency=0, busy=0, done=0.
REQ-031 Reset mid-playback abandons the sequence without a done pulse.

Structure
REQ-032 Shared package simon_pkg holds the state enum, the color type (2-bit), and GAME_TONES = {415, 310, 252, 209} (10-bit, index 0..3).
REQ-033 One sub-module, step_timer (loadable TIMER_W-bit down-counter with zero flag); all else in seq_playback_ctrl.

Verification (ON_CYCLES=4, GAP_CYCLES=2)
REQ-034 mem[0]=2, start at T with seq_length=1 -> mem_rd_en/addr 0 at T+1; led=0100, frequency=252 for T+3..T+6; silent T+7..T+8; done at T+9 only; busy T+1..T+9.
REQ-035 mem={0,3,1}, seq_length=3 -> led 0001, 1000, 0010 in order, each exactly 4 cycles; addresses 0,1,2; done at T+25.
REQ-036 start with seq_length=0 -> no mem_rd_en, done at T+1, busy only at T+1.
REQ-037 abort in 2nd cycle of TONE_ON -> led/frequency 0 next cycle, IDLE, no done; a following start restarts at address 0.
REQ-038 start pulses and seq_length changes during playback -> ignored, timing identical to REQ-035.
REQ-039 rst_n=0 during GAP -> all outputs 0 next cycle, no done; seq_length=31 run -> 31 steps, last address 30.
